// File: rtl/frame_capture_sched.sv
// Frame capture scheduler: gates an upstream pixel stream into a ping-pong buffer pair,
// capturing one frame then discarding skip_cnt frames. FRAME_SCHED_DROP_CNT_EN enables the overrun counter.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 2
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 2'd0
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 2'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 2'd2
`endif

// state   | meaning
// IDLE    | not scheduled; stream suppressed
// ARMED   | waiting for a frame boundary; stream suppressed
// CAPTURE | forwarding the current frame into buffer wbuf
// SKIP    | discarding the current frame (skip interval or overrun)
module frame_capture_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clki,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    abort,
    input  logic [7:0]              skip_cnt,
    input  logic [CNT_WIDTH-1:0]    num_frames,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    input  logic                    rel_valid,
    input  logic                    rel_buf,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic                    wbuf,
    output logic [1:0]              buf_full,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    frames_captured,
    output logic [CNT_WIDTH-1:0]    frames_dropped
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_SKIP    = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             skip_ctr;
    logic [7:0]             skip_nxt;
    logic                   fwd;
    logic                   mark_full;
    logic                   cnt_clr;
    logic                   cap_bump;
    logic                   drop_bump;
    logic                   done_nxt;
    logic [1:0]             buf_full_nxt;
    logic [CNT_WIDTH-1:0]   cap_sat;
    logic                   is_fs;
    logic                   is_fe;

    assign is_fs   = dvi && (dtypei == `DTYPE_FRAME_START);
    assign is_fe   = dvi && (dtypei == `DTYPE_FRAME_END);
    assign cap_sat = (frames_captured == '1) ? frames_captured
                                             : frames_captured + CNT_WIDTH'(1);
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_ctr;
        fwd       = 1'b0;
        mark_full = 1'b0;
        cnt_clr   = 1'b0;
        cap_bump  = 1'b0;
        drop_bump = 1'b0;
        done_nxt  = 1'b0;
        if (!enable || abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_clr   = 1'b1;
                        skip_nxt  = 8'd0;
                        state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (is_fs) begin
                        if (skip_ctr != 8'd0) begin
                            skip_nxt  = skip_ctr - 8'd1;
                            state_nxt = S_SKIP;
                        end else if (buf_full[wbuf]) begin
                            // overrun: skip_ctr stays 0 so the very next frame retries
                            drop_bump = 1'b1;
                            state_nxt = S_SKIP;
                        end else begin
                            fwd       = 1'b1;
                            state_nxt = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    fwd = dvi;
                    if (is_fe) begin
                        mark_full = 1'b1;
                        cap_bump  = 1'b1;
                        skip_nxt  = skip_cnt;
                        if ((num_frames != '0) && (cap_sat == num_frames)) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_ARMED;
                        end
                    end
                end
                S_SKIP: begin
                    if (is_fe)
                        state_nxt = S_ARMED;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // release first, mark second: a same-bit set overrides the clear
    always_comb begin
        buf_full_nxt = buf_full;
        if (rel_valid)
            buf_full_nxt[rel_buf] = 1'b0;
        if (mark_full)
            buf_full_nxt[wbuf] = 1'b1;
    end

    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb) begin
            state           <= S_IDLE;
            skip_ctr        <= 8'd0;
            dvo             <= 1'b0;
            dtypeo          <= '0;
            datao           <= '0;
            wbuf            <= 1'b0;
            buf_full        <= 2'b00;
            done            <= 1'b0;
            frames_captured <= '0;
        end else begin
            state    <= state_nxt;
            skip_ctr <= skip_nxt;
            dvo      <= fwd;
            dtypeo   <= dtypei;
            datao    <= datai;
            buf_full <= buf_full_nxt;
            done     <= done_nxt;
            if (mark_full)
                wbuf <= ~wbuf;
            if (cnt_clr)
                frames_captured <= '0;
            else if (cap_bump)
                frames_captured <= cap_sat;
        end
    end

`ifdef FRAME_SCHED_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] drop_q;

    always_ff @(posedge clki or negedge resetb) begin
        if (!resetb)
            drop_q <= '0;
        else if (cnt_clr)
            drop_q <= '0;
        else if (drop_bump && (drop_q != '1))
            drop_q <= drop_q + CNT_WIDTH'(1);
    end

    assign frames_dropped = drop_q;
`else
    logic drop_bump_unused;

    assign drop_bump_unused = drop_bump;
    assign frames_dropped   = '0;
`endif

endmodule

// File: tb/tb_frame_capture_sched.sv
// Directed and randomized bench for frame_capture_sched with a frame-level reference model.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 2
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 2'd0
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 2'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 2'd2
`endif

module tb_frame_capture_sched;
    localparam int DW = 16;
    localparam int CW = 16;

    logic                    clki = 1'b0;
    logic                    resetb;
    logic                    enable;
    logic                    start;
    logic                    abort;
    logic [7:0]              skip_cnt;
    logic [CW-1:0]           num_frames;
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic [DW-1:0]           datai;
    logic                    rel_valid;
    logic                    rel_buf;
    logic                    dvo;
    logic [`DTYPE_WIDTH-1:0] dtypeo;
    logic [DW-1:0]           datao;
    logic                    wbuf;
    logic [1:0]              buf_full;
    logic                    busy;
    logic                    done;
    logic [CW-1:0]           frames_captured;
    logic [CW-1:0]           frames_dropped;

    int checks = 0;
    int errors = 0;

    frame_capture_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clki(clki), .resetb(resetb), .enable(enable), .start(start), .abort(abort),
        .skip_cnt(skip_cnt), .num_frames(num_frames),
        .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .rel_valid(rel_valid), .rel_buf(rel_buf),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
        .wbuf(wbuf), .buf_full(buf_full), .busy(busy), .done(done),
        .frames_captured(frames_captured), .frames_dropped(frames_dropped)
    );

    always #5 clki = ~clki;

    function automatic int exp_drop(input int n);
`ifdef FRAME_SCHED_DROP_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // apply one beat, let one edge pass, check the registered output one cycle later
    task automatic beat(input logic v, input logic [1:0] t, input logic [DW-1:0] d,
                        input logic fwd, input logic exp_done, input string tag);
        dvi    = v;
        dtypei = t;
        datai  = d;
        @(posedge clki);
        #1;
        chk({tag, "_dvo"}, {31'd0, dvo}, {31'd0, fwd});
        if (fwd) begin
            chk({tag, "_datao"}, {16'd0, datao}, {16'd0, d});
            chk({tag, "_dtypeo"}, {30'd0, dtypeo}, {30'd0, t});
        end
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        start     = 1'b0;
        abort     = 1'b0;
        rel_valid = 1'b0;
        dvi       = 1'b0;
    endtask

    task automatic gap(input string tag);
        beat(1'b0, `DTYPE_PIXEL_MASK, '0, 1'b0, 1'b0, tag);
    endtask

    task automatic rel(input logic b, input string tag);
        rel_valid = 1'b1;
        rel_buf   = b;
        gap(tag);
    endtask

    task automatic send_frame(input int npix, input logic fwd, input logic done_end, input string tag);
        beat(1'b1, `DTYPE_FRAME_START, DW'($urandom), fwd, 1'b0, {tag, "_fs"});
        for (int i = 0; i < npix; i++)
            beat(1'b1, `DTYPE_PIXEL_MASK, DW'($urandom), fwd, 1'b0, {tag, "_px"});
        beat(1'b1, `DTYPE_FRAME_END, DW'($urandom), fwd, done_end, {tag, "_fe"});
    endtask

    initial begin
        logic       fw;
        logic       wb;
        logic [1:0] m_full;
        logic       m_wbuf;
        int         m_skip;
        int         m_cap;
        int         m_drop;
        int         rskip;
        int         npix;
        logic       rb;

        resetb = 1'b0; enable = 1'b0; start = 1'b0; abort = 1'b0;
        skip_cnt = 8'd0; num_frames = '0; dvi = 1'b0; dtypei = '0; datai = '0;
        rel_valid = 1'b0; rel_buf = 1'b0;
        #12;
        chk("rst_dvo", {31'd0, dvo}, 0);
        chk("rst_wbuf", {31'd0, wbuf}, 0);
        chk("rst_full", {30'd0, buf_full}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_cap", {16'd0, frames_captured}, 0);
        chk("rst_drop", {16'd0, frames_dropped}, 0);
        @(posedge clki);
        #2;
        resetb = 1'b1;
        enable = 1'b1;
        beat(1'b1, `DTYPE_FRAME_START, 16'h1234, 1'b0, 1'b0, "rel_edge");
        chk("rel_busy", {31'd0, busy}, 0);

        // skip 2: frames 1,4,7 of 9 captured, ping-ponging 0,1,0
        skip_cnt = 8'd2; num_frames = '0;
        start = 1'b1;
        gap("r40_start");
        chk("r40_busy", {31'd0, busy}, 1);
        wb = 1'b0;
        for (int f = 1; f <= 9; f++) begin
            fw = (f % 3 == 1);
            if (fw) chk("r40_wbuf", {31'd0, wbuf}, {31'd0, wb});
            send_frame(3, fw, 1'b0, "r40");
            if (fw) begin
                rel(wb, "r40_rel");
                wb = ~wb;
            end else begin
                gap("r40_gap");
            end
        end
        chk("r40_cap", {16'd0, frames_captured}, 3);
        chk("r40_drop", {16'd0, frames_dropped}, 0);
        chk("r40_full", {30'd0, buf_full}, 0);
        abort = 1'b1;
        gap("r40_abort");
        chk("r40_idle", {31'd0, busy}, 0);

        // two-frame run terminates with done
        skip_cnt = 8'd0; num_frames = 16'd2;
        start = 1'b1;
        gap("r41_start");
        send_frame(4, 1'b1, 1'b0, "r41_f1");
        rel(1'b1, "r41_rel");
        send_frame(4, 1'b1, 1'b1, "r41_f2");
        chk("r41_busy", {31'd0, busy}, 0);
        chk("r41_cap", {16'd0, frames_captured}, 2);
        gap("r41_gap");
        send_frame(2, 1'b0, 1'b0, "r41_f3");
        rel(1'b0, "r41_rel0");
        chk("r41_full", {30'd0, buf_full}, 0);
        chk("r41_wbuf", {31'd0, wbuf}, 1);

        // no releases: two captures then two overruns
        num_frames = '0;
        start = 1'b1;
        gap("r42_start");
        send_frame(2, 1'b1, 1'b0, "r42_f1");
        send_frame(2, 1'b1, 1'b0, "r42_f2");
        send_frame(2, 1'b0, 1'b0, "r42_f3");
        send_frame(2, 1'b0, 1'b0, "r42_f4");
        chk("r42_full", {30'd0, buf_full}, 3);
        chk("r42_cap", {16'd0, frames_captured}, 2);
        chk("r42_drop", {16'd0, frames_dropped}, exp_drop(2));
        abort = 1'b1;
        gap("r42_abort");
        chk("r42_idle", {31'd0, busy}, 0);
        rel(1'b0, "r42_rel0");
        chk("r42_full_rel0", {30'd0, buf_full}, 2);
        rel(1'b1, "r42_rel1");
        chk("r42_full_rel1", {30'd0, buf_full}, 0);
        chk("r42_wbuf", {31'd0, wbuf}, 1);

        // arming mid-frame suppresses the tail of that frame
        beat(1'b1, `DTYPE_FRAME_START, 16'h0a0a, 1'b0, 1'b0, "r43_fs");
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h0b0b, 1'b0, 1'b0, "r43_px0");
        start = 1'b1;
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h0c0c, 1'b0, 1'b0, "r43_px1");
        chk("r43_busy", {31'd0, busy}, 1);
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h0d0d, 1'b0, 1'b0, "r43_px2");
        beat(1'b1, `DTYPE_FRAME_END, 16'h0e0e, 1'b0, 1'b0, "r43_fe");
        gap("r43_gap");
        send_frame(2, 1'b1, 1'b0, "r43_next");
        chk("r43_full", {30'd0, buf_full}, 2);
        chk("r43_wbuf", {31'd0, wbuf}, 0);

        // abort on the 10th pixel of a captured frame
        beat(1'b1, `DTYPE_FRAME_START, DW'($urandom), 1'b1, 1'b0, "r44_fs");
        for (int i = 0; i < 9; i++)
            beat(1'b1, `DTYPE_PIXEL_MASK, DW'($urandom), 1'b1, 1'b0, "r44_px");
        abort = 1'b1;
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h5555, 1'b0, 1'b0, "r44_abort_px");
        chk("r44_busy", {31'd0, busy}, 0);
        chk("r44_full", {30'd0, buf_full}, 2);
        chk("r44_wbuf", {31'd0, wbuf}, 0);
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h6666, 1'b0, 1'b0, "r44_after");
        beat(1'b1, `DTYPE_FRAME_END, 16'h7777, 1'b0, 1'b0, "r44_fe");

        // simultaneous set and release
        start = 1'b1;
        gap("r45_start");
        beat(1'b1, `DTYPE_FRAME_START, DW'($urandom), 1'b1, 1'b0, "r45_fs");
        beat(1'b1, `DTYPE_PIXEL_MASK, DW'($urandom), 1'b1, 1'b0, "r45_px");
        rel_valid = 1'b1; rel_buf = 1'b0;
        beat(1'b1, `DTYPE_FRAME_END, DW'($urandom), 1'b1, 1'b0, "r45_fe_same");
        chk("r45_full_same", {30'd0, buf_full}, 3);
        chk("r45_wbuf_same", {31'd0, wbuf}, 1);
        rel(1'b1, "r45_rel1");
        chk("r45_full_rel1", {30'd0, buf_full}, 1);
        beat(1'b1, `DTYPE_FRAME_START, DW'($urandom), 1'b1, 1'b0, "r45_fs2");
        beat(1'b1, `DTYPE_PIXEL_MASK, DW'($urandom), 1'b1, 1'b0, "r45_px2");
        rel_valid = 1'b1; rel_buf = 1'b0;
        beat(1'b1, `DTYPE_FRAME_END, DW'($urandom), 1'b1, 1'b0, "r45_fe_diff");
        chk("r45_full_diff", {30'd0, buf_full}, 2);
        chk("r45_wbuf_diff", {31'd0, wbuf}, 0);
        abort = 1'b1;
        gap("r45_abort");

        // asynchronous reset between edges
        @(posedge clki);
        #3;
        resetb = 1'b0;
        #1;
        chk("arst_full", {30'd0, buf_full}, 0);
        chk("arst_cap", {16'd0, frames_captured}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        @(posedge clki);
        #2;
        resetb = 1'b1;
        beat(1'b1, `DTYPE_FRAME_START, 16'h4321, 1'b0, 1'b0, "arst_rel");

        // randomized frames against a frame-level model
        rskip = $urandom_range(0, 3);
        skip_cnt = 8'(rskip); num_frames = '0;
        m_full = 2'b00; m_wbuf = 1'b0; m_skip = 0; m_cap = 0; m_drop = 0;
        start = 1'b1;
        gap("rnd_start");
        for (int f = 0; f < 40; f++) begin
            if (m_skip != 0) begin
                m_skip--;
                fw = 1'b0;
            end else if (m_full[m_wbuf]) begin
                m_drop++;
                fw = 1'b0;
            end else begin
                fw = 1'b1;
            end
            npix = $urandom_range(1, 5);
            beat(1'b1, `DTYPE_FRAME_START, DW'($urandom), fw, 1'b0, "rnd_fs");
            for (int i = 0; i < npix; i++) begin
                if ($urandom_range(0, 3) == 0) gap("rnd_hole");
                beat(1'b1, `DTYPE_PIXEL_MASK, DW'($urandom), fw, 1'b0, "rnd_px");
            end
            beat(1'b1, `DTYPE_FRAME_END, DW'($urandom), fw, 1'b0, "rnd_fe");
            if (fw) begin
                m_full[m_wbuf] = 1'b1;
                m_wbuf = ~m_wbuf;
                m_cap++;
                m_skip = rskip;
            end
            chk("rnd_cap", {16'd0, frames_captured}, m_cap);
            chk("rnd_drop", {16'd0, frames_dropped}, exp_drop(m_drop));
            chk("rnd_full", {30'd0, buf_full}, {30'd0, m_full});
            chk("rnd_wbuf", {31'd0, wbuf}, {31'd0, m_wbuf});
            if ($urandom_range(0, 2) != 0) begin
                rb = 1'($urandom_range(0, 1));
                rel(rb, "rnd_rel");
                m_full[rb] = 1'b0;
            end else begin
                gap("rnd_gap");
            end
        end

        // dropping enable mid-capture
        abort = 1'b1;
        gap("en_abort");
        rel(1'b0, "en_rel0");
        rel(1'b1, "en_rel1");
        skip_cnt = 8'd0;
        start = 1'b1;
        gap("en_start");
        beat(1'b1, `DTYPE_FRAME_START, 16'h2468, 1'b1, 1'b0, "en_fs");
        enable = 1'b0;
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h1357, 1'b0, 1'b0, "en_px");
        chk("en_busy", {31'd0, busy}, 0);
        enable = 1'b1;
        beat(1'b1, `DTYPE_PIXEL_MASK, 16'h9999, 1'b0, 1'b0, "en_px2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_capture_sched.md
FRAME_CAPTURE_SCHED -- requirements
Module: frame_capture_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 16, stream pixel data width.
REQ-002 Parameter CNT_WIDTH, default 16, width of frame count and counter outputs.
REQ-003 clki  input  1  clock; all logic is synchronous to its rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  synchronous; low forces IDLE with outputs quiet.
REQ-006 start  input  1  one-cycle pulse; arms a capture sequence.
REQ-007 abort  input  1  one-cycle pulse; ends the sequence.
REQ-008 skip_cnt  input  8  frames discarded between captured frames.
REQ-009 num_frames  input  CNT_WIDTH  frames to capture; 0 means run until abort.
REQ-010 dvi / dtypei / datai  input  1 / `DTYPE_WIDTH / DATA_WIDTH  upstream stream beat.
REQ-011 rel_valid / rel_buf  input  1 / 1  reader releases buffer rel_buf.
REQ-012 dvo / dtypeo / datao  output  1 / `DTYPE_WIDTH / DATA_WIDTH  gated stream to the double buffer.
REQ-013 wbuf  output  1  buffer index being written.
REQ-014 buf_full  output  2  per-buffer full flag.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse when num_frames have been captured.
REQ-017 frames_captured / frames_dropped  output  CNT_WIDTH each  statistics.

Function
REQ-018 States are IDLE, ARMED, CAPTURE and SKIP; `DTYPE_FRAME_START, `DTYPE_FRAME_END and `DTYPE_PIXEL_MASK classify beats.
REQ-019 The forwarding path has 1-cycle latency: dvo is registered dvi when the beat is forwarded and 0 otherwise; dtypeo/datao are registered copies of dtypei/datai.
REQ-020 IDLE + start: clear frames_captured, frames_dropped and skip_ctr, go ARMED; start is ignored while busy.
REQ-021 ARMED: all beats are suppressed, so mid-frame arming never forwards a partial frame.
REQ-022 ARMED + FRAME_START, skip_ctr!=0: decrement skip_ctr, go SKIP.
REQ-023 ARMED + FRAME_START, skip_ctr==0, buf_full[wbuf]==0: forward the beat, go CAPTURE.
REQ-024 ARMED + FRAME_START, skip_ctr==0, buf_full[wbuf]==1: buffer overrun; go SKIP, increment frames_dropped, keep skip_ctr at 0 so the next frame retries.
REQ-025 CAPTURE: forward every dvi beat; a repeated FRAME_START is forwarded with no state change.
REQ-026 CAPTURE + FRAME_END: forward it, set buf_full[wbuf], toggle wbuf, increment frames_captured, load skip_ctr=skip_cnt.
REQ-027 After REQ-026, if num_frames!=0 and the new frames_captured==num_frames: pulse done next cycle, go IDLE; otherwise go ARMED.
REQ-028 SKIP: suppress all beats; FRAME_END returns to ARMED.
REQ-029 rel_valid clears buf_full[rel_buf] in any state, including IDLE.
REQ-030 A set (REQ-026) and a clear on the same bit in one cycle: the set wins; a set and a clear on different bits both apply.
REQ-031 abort, or enable low, in any state: go IDLE next cycle with no further beats forwarded.
REQ-032 An abort mid-CAPTURE leaves the partial frame unmarked: buf_full and wbuf are unchanged, and the buffer is overwritten by the next capture.
REQ-033 abort and start in the same cycle: abort wins.
REQ-034 Counters saturate at all-ones and do not wrap.
REQ-035 skip_cnt and num_frames are sampled live; they must be held stable while busy.

Reset
REQ-036 resetb low asynchronously forces IDLE and sets dvo, dtypeo, datao, wbuf, buf_full, busy, done, skip_ctr and both counters to 0.
REQ-037 Release of resetb takes effect on the first clki edge after deassertion; no beat is forwarded on that edge.

Configuration
REQ-038 With FRAME_SCHED_DROP_CNT_EN defined, frames_dropped counts overruns per REQ-024.
REQ-039 Without FRAME_SCHED_DROP_CNT_EN, frames_dropped is constant 0 and no counter register exists; overrun skipping behaviour is unchanged.

Verification
REQ-040 skip_cnt=2, num_frames=0, buffers released promptly, 9 frames -> frames 1,4,7 forwarded; wbuf sequence 0,1,0; frames_captured=3.
REQ-041 num_frames=2, skip_cnt=0 -> 2 frames forwarded, done pulses once after the second FRAME_END, busy falls, the third frame is not forwarded.
REQ-042 skip_cnt=0, no rel_valid, 4 frames -> frames 1 and 2 captured, buf_full=2'b11, frames 3 and 4 dropped, frames_dropped=2 (0 without the macro).
REQ-043 start mid-frame -> rest of that frame suppressed; next FRAME_START forwarded at 1-cycle latency.
REQ-044 abort on the 10th pixel of a captured frame -> no dvo after 1 cycle; buf_full and wbuf unchanged; busy=0.
REQ-045 FRAME_END on wbuf=0 in the same cycle as rel_valid with rel_buf=0 -> buf_full[0]=1 afterwards.
